// File: rtl/hyperbus_axi_bist_if.sv
// AXI4 channel bundle between the self-test master and the hyperbus AXI slave port.
// Single ID, INCR bursts only; unused AXI sideband signals are not carried.
interface hyperbus_axi_bist_if #(
   parameter int unsigned AddrWidth = 32,
   parameter int unsigned DataWidth = 128
);
   localparam int unsigned StrbWidth = DataWidth / 8;

   logic                 aw_valid;
   logic                 aw_ready;
   logic [AddrWidth-1:0] aw_addr;
   logic [7:0]           aw_len;
   logic [2:0]           aw_size;
   logic [1:0]           aw_burst;

   logic                 w_valid;
   logic                 w_ready;
   logic [DataWidth-1:0] w_data;
   logic [StrbWidth-1:0] w_strb;
   logic                 w_last;

   logic                 b_valid;
   logic                 b_ready;
   logic [1:0]           b_resp;

   logic                 ar_valid;
   logic                 ar_ready;
   logic [AddrWidth-1:0] ar_addr;
   logic [7:0]           ar_len;
   logic [2:0]           ar_size;
   logic [1:0]           ar_burst;

   logic                 r_valid;
   logic                 r_ready;
   logic [DataWidth-1:0] r_data;
   logic [1:0]           r_resp;
   logic                 r_last;

   modport master (
      output aw_valid, aw_addr, aw_len, aw_size, aw_burst,
      input  aw_ready,
      output w_valid, w_data, w_strb, w_last,
      input  w_ready,
      input  b_valid, b_resp,
      output b_ready,
      output ar_valid, ar_addr, ar_len, ar_size, ar_burst,
      input  ar_ready,
      input  r_valid, r_data, r_resp, r_last,
      output r_ready
   );

   modport slave (
      input  aw_valid, aw_addr, aw_len, aw_size, aw_burst,
      output aw_ready,
      input  w_valid, w_data, w_strb, w_last,
      output w_ready,
      output b_valid, b_resp,
      input  b_ready,
      input  ar_valid, ar_addr, ar_len, ar_size, ar_burst,
      output ar_ready,
      output r_valid, r_data, r_resp, r_last,
      input  r_ready
   );
endinterface

// File: rtl/hyperbus_axi_bist.sv
// AXI4 self-test master: writes one LFSR-patterned INCR burst, reads it back and
// counts response, strobed-data and last-beat errors in a saturating counter.
module hyperbus_axi_bist #(
   parameter int unsigned AddrWidth   = 32,
   parameter int unsigned DataWidth   = 128,
   parameter int unsigned ErrCntWidth = 16
) (
   input  logic                   clk_i,
   input  logic                   rst_ni,
   input  logic                   start_i,
   input  logic [AddrWidth-1:0]   cfg_addr_i,
   input  logic [7:0]             cfg_len_i,
   input  logic [2:0]             cfg_size_i,
   input  logic [31:0]            cfg_seed_i,
   output logic                   busy_o,
   output logic                   done_o,
   output logic                   cfg_err_o,
   output logic                   err_o,
   output logic [ErrCntWidth-1:0] err_cnt_o,
   hyperbus_axi_bist_if.master    axi
);

   localparam int unsigned StrbWidth = DataWidth / 8;
   localparam int unsigned LaneWidth = $clog2(StrbWidth);
   localparam logic [31:0] LfsrPoly  = 32'h8020_0003;
   localparam logic [1:0]  BurstIncr = 2'b01;
   localparam logic [1:0]  RespOkay  = 2'b00;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_AW,
      ST_W,
      ST_B,
      ST_AR,
      ST_R,
      ST_FIN
   } state_e;

   state_e state_q, state_d;

   logic [AddrWidth-1:0]   addr_q;
   logic [7:0]             len_q;
   logic [2:0]             size_q;
   logic [31:0]            seed_q;
   logic [31:0]            lfsr_q;
   logic [7:0]             beat_q;
   logic [LaneWidth-1:0]   lane_q;
   logic [ErrCntWidth-1:0] err_cnt_q;
   logic                   cfg_err_q;
   logic                   rej_done_q;

   logic       accept, reject, beat_adv, rewind;
   logic [1:0] err_inc;
   logic       aw_valid, w_valid, b_ready, ar_valid, r_ready;

   logic [8:0]           len_p1;
   logic [16:0]          span_end;
   logic                 cfg_bad;
   logic                 is_last;
   logic [31:0]          seed_fix;
   logic [StrbWidth-1:0] strb;
   logic [DataWidth-1:0] word, w_data;
   logic                 data_bad;
   logic [ErrCntWidth:0] cnt_sum;

   function automatic logic [31:0] lfsr_next(input logic [31:0] v);
      return (v >> 1) ^ (v[0] ? LfsrPoly : 32'h0);
   endfunction

   // Reject misaligned starts, oversized beats and bursts ending past a 4KiB page.
   always_comb begin
      len_p1   = {1'b0, cfg_len_i} + 9'd1;
      span_end = {5'd0, cfg_addr_i[11:0]} + ({8'd0, len_p1} << cfg_size_i);
      cfg_bad  = (cfg_size_i > 3'(LaneWidth))
              || ((cfg_addr_i[6:0] & ((7'd1 << cfg_size_i) - 7'd1)) != 7'd0)
              || (span_end > 17'd4096);
   end

   assign seed_fix = (cfg_seed_i == 32'd0) ? 32'd1 : cfg_seed_i;
   assign is_last  = (beat_q == len_q);
   assign word     = {(DataWidth / 32){lfsr_q}};

   // Byte lanes [lane, lane + 2**size) modulo the bus width.
   always_comb begin
      logic [LaneWidth-1:0] off;
      strb     = '0;
      w_data   = '0;
      data_bad = 1'b0;
      for (int unsigned i = 0; i < StrbWidth; i++) begin
         off     = LaneWidth'(i) - lane_q;
         strb[i] = (32'(off) < (32'd1 << size_q));
         if (strb[i]) begin
            w_data[8*i +: 8] = word[8*i +: 8];
            if (axi.r_data[8*i +: 8] != word[8*i +: 8]) begin
               data_bad = 1'b1;
            end
         end
      end
   end

   always_comb begin
      state_d  = state_q;
      accept   = 1'b0;
      reject   = 1'b0;
      beat_adv = 1'b0;
      rewind   = 1'b0;
      err_inc  = 2'd0;
      aw_valid = 1'b0;
      w_valid  = 1'b0;
      b_ready  = 1'b0;
      ar_valid = 1'b0;
      r_ready  = 1'b0;
      unique case (state_q)
         ST_IDLE: begin
            if (start_i) begin
               if (cfg_bad) begin
                  reject = 1'b1;
               end else begin
                  accept  = 1'b1;
                  state_d = ST_AW;
               end
            end
         end
         ST_AW: begin
            aw_valid = 1'b1;
            if (axi.aw_ready) state_d = ST_W;
         end
         ST_W: begin
            w_valid = 1'b1;
            if (axi.w_ready) begin
               beat_adv = 1'b1;
               if (is_last) state_d = ST_B;
            end
         end
         ST_B: begin
            b_ready = 1'b1;
            if (axi.b_valid) begin
               rewind  = 1'b1;
               err_inc = {1'b0, axi.b_resp != RespOkay};
               state_d = ST_AR;
            end
         end
         ST_AR: begin
            ar_valid = 1'b1;
            if (axi.ar_ready) state_d = ST_R;
         end
         ST_R: begin
            r_ready = 1'b1;
            if (axi.r_valid) begin
               beat_adv = 1'b1;
               err_inc  = {1'b0, axi.r_resp != RespOkay}
                        + {1'b0, data_bad}
                        + {1'b0, axi.r_last != is_last};
               if (axi.r_last || is_last) state_d = ST_FIN;
            end
         end
         ST_FIN: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   assign cnt_sum = {1'b0, err_cnt_q} + {{(ErrCntWidth-1){1'b0}}, err_inc};

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         addr_q     <= '0;
         len_q      <= '0;
         size_q     <= '0;
         seed_q     <= '0;
         lfsr_q     <= '0;
         beat_q     <= '0;
         lane_q     <= '0;
         err_cnt_q  <= '0;
         cfg_err_q  <= 1'b0;
         rej_done_q <= 1'b0;
      end else begin
         rej_done_q <= reject;
         if (accept || reject) cfg_err_q <= reject;
         if (accept) begin
            addr_q    <= cfg_addr_i;
            len_q     <= cfg_len_i;
            size_q    <= cfg_size_i;
            seed_q    <= seed_fix;
            lfsr_q    <= seed_fix;
            beat_q    <= '0;
            lane_q    <= cfg_addr_i[LaneWidth-1:0];
            err_cnt_q <= '0;
         end else if (rewind) begin
            lfsr_q <= seed_q;
            beat_q <= '0;
            lane_q <= addr_q[LaneWidth-1:0];
         end else if (beat_adv) begin
            lfsr_q <= lfsr_next(lfsr_q);
            beat_q <= beat_q + 8'd1;
            lane_q <= lane_q + LaneWidth'(32'd1 << size_q);
         end
         if (err_inc != 2'd0) begin
            err_cnt_q <= cnt_sum[ErrCntWidth] ? '1 : cnt_sum[ErrCntWidth-1:0];
         end
      end
   end

   assign busy_o    = (state_q != ST_IDLE) && (state_q != ST_FIN);
   assign done_o    = (state_q == ST_FIN) || rej_done_q;
   assign cfg_err_o = cfg_err_q;
   assign err_o     = (err_cnt_q != '0) || cfg_err_q;
   assign err_cnt_o = err_cnt_q;

   assign axi.aw_valid = aw_valid;
   assign axi.aw_addr  = addr_q;
   assign axi.aw_len   = len_q;
   assign axi.aw_size  = size_q;
   assign axi.aw_burst = BurstIncr;
   assign axi.w_valid  = w_valid;
   assign axi.w_data   = w_data;
   assign axi.w_strb   = strb;
   assign axi.w_last   = is_last;
   assign axi.b_ready  = b_ready;
   assign axi.ar_valid = ar_valid;
   assign axi.ar_addr  = addr_q;
   assign axi.ar_len   = len_q;
   assign axi.ar_size  = size_q;
   assign axi.ar_burst = BurstIncr;
   assign axi.r_ready  = r_ready;

endmodule
